// File: rtl/cordic_pkg.sv
// Shared fixed-point definitions and the atan(2^-i) angle table for the CORDIC pipeline.
package cordic_pkg;

    localparam int DEFAULT_FRAC_BITS = 30;
    localparam int DEFAULT_W         = DEFAULT_FRAC_BITS + 2;

    typedef logic signed [DEFAULT_W-1:0] fixed_t;

    // Q2.FRAC_BITS data word: two integer bits (sign + one) above the fraction.
    function automatic int data_width(input int frac_bits);
        return frac_bits + 2;
    endfunction

    // atan(2^-i) in Q2.30, rounded to nearest; the pipeline wrapper feeds entry i into stage i.
    localparam int ATAN_DEPTH = 16;
    localparam fixed_t ATAN_TABLE [ATAN_DEPTH] = '{
        32'sh3243F6A9, 32'sh1DAC6705, 32'sh0FADBAFD, 32'sh07F56EA7,
        32'sh03FEAB77, 32'sh01FFD55C, 32'sh00FFFAAB, 32'sh007FFF55,
        32'sh003FFFEB, 32'sh001FFFFD, 32'sh00100000, 32'sh00080000,
        32'sh00040000, 32'sh00020000, 32'sh00010000, 32'sh00008000
    };

endpackage

// File: rtl/cordic_micro_rotation.sv
// Combinational CORDIC micro-rotation: direction decode, two arithmetic shifters, three add/sub.
module cordic_micro_rotation #(
    parameter int          W         = 32,
    parameter int          ITERATION = 0,
    parameter logic [W-1:0] ANGLE    = '0
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] z,
    output logic signed [W-1:0] x_next,
    output logic signed [W-1:0] y_next,
    output logic signed [W-1:0] z_next
);

    logic                dir_neg;
    logic signed [W-1:0] x_shift;
    logic signed [W-1:0] y_shift;
    logic signed [W-1:0] angle;

    // Zero residual counts as non-negative, so only the sign bit decides direction.
    assign dir_neg = z[W-1];
    assign x_shift = x >>> ITERATION;
    assign y_shift = y >>> ITERATION;
    assign angle   = ANGLE;

    assign x_next = dir_neg ? (x + y_shift) : (x - y_shift);
    assign y_next = dir_neg ? (y - x_shift) : (y + x_shift);
    assign z_next = dir_neg ? (z + angle)   : (z - angle);

endmodule

// File: rtl/cordic_iteration.sv
// One registered CORDIC rotation-mode stage; chains with other stages at one stage per clock.
module cordic_iteration
    import cordic_pkg::*;
#(
    parameter int                   FRAC_BITS = DEFAULT_FRAC_BITS,
    parameter int                   ITERATION = 0,
    parameter logic [FRAC_BITS+1:0] ANGLE     = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic signed [FRAC_BITS+1:0] x_in,
    input  logic signed [FRAC_BITS+1:0] y_in,
    input  logic signed [FRAC_BITS+1:0] z_in,
    output logic                        valid_out,
    output logic signed [FRAC_BITS+1:0] x_out,
    output logic signed [FRAC_BITS+1:0] y_out,
    output logic signed [FRAC_BITS+1:0] z_out
);

    localparam int W = data_width(FRAC_BITS);

    logic signed [W-1:0] x_next;
    logic signed [W-1:0] y_next;
    logic signed [W-1:0] z_next;

    cordic_micro_rotation #(
        .W         (W),
        .ITERATION (ITERATION),
        .ANGLE     (ANGLE)
    ) u_rot (
        .x      (x_in),
        .y      (y_in),
        .z      (z_in),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

    // Data loads every cycle; valid only tags which outputs downstream should use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else begin
            valid_out <= valid_in;
            x_out     <= x_next;
            y_out     <= y_next;
            z_out     <= z_next;
        end
    end

endmodule

// File: tb/tb_cordic_iteration.sv
// Bench for cordic_iteration: four stage configurations driven in parallel, checked against a 64-bit model.
module tb_cordic_iteration;

    localparam int NI = 4;
    localparam int IT [NI] = '{1, 0, 1, 3};
    localparam logic [31:0] AN [NI] = '{32'h20000000, 32'h3243F6A9, 32'h00000000, 32'h07F56EA7};

    typedef struct packed {
        logic             v;
        logic [3:0][31:0] x;
        logic [3:0][31:0] y;
        logic [3:0][31:0] z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic [31:0] z_in = '0;
    logic        vo [NI];
    logic [31:0] xo [NI];
    logic [31:0] yo [NI];
    logic [31:0] zo [NI];

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    cordic_iteration #(.FRAC_BITS(30), .ITERATION(1), .ANGLE(32'h20000000)) u_half (
        .clk(clk), .rst(rst), .valid_in(valid_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .valid_out(vo[0]), .x_out(xo[0]), .y_out(yo[0]), .z_out(zo[0]));
    cordic_iteration #(.FRAC_BITS(30), .ITERATION(0), .ANGLE(32'h3243F6A9)) u_pi4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .valid_out(vo[1]), .x_out(xo[1]), .y_out(yo[1]), .z_out(zo[1]));
    cordic_iteration #(.FRAC_BITS(30), .ITERATION(1), .ANGLE(32'h00000000)) u_zero (
        .clk(clk), .rst(rst), .valid_in(valid_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .valid_out(vo[2]), .x_out(xo[2]), .y_out(yo[2]), .z_out(zo[2]));
    cordic_iteration #(.FRAC_BITS(30), .ITERATION(3), .ANGLE(32'h07F56EA7)) u_it3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .valid_out(vo[3]), .x_out(xo[3]), .y_out(yo[3]), .z_out(zo[3]));

    function automatic exp_t model(input logic v, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] z);
        exp_t   e;
        longint xs, ys, zs, a, dx, dy, xn, yn, zn;
        e.v = v;
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        zs = longint'($signed(z));
        for (int k = 0; k < NI; k++) begin
            a  = longint'($signed(AN[k]));
            dx = xs >>> IT[k];
            dy = ys >>> IT[k];
            if (zs >= 0) begin
                xn = xs - dy; yn = ys + dx; zn = zs - a;
            end else begin
                xn = xs + dy; yn = ys - dx; zn = zs + a;
            end
            e.x[k] = xn[31:0];
            e.y[k] = yn[31:0];
            e.z[k] = zn[31:0];
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        valid_in = v;
        x_in     = x;
        y_in     = y;
        z_in     = z;
        sb.push_back(model(v, x, y, z));
    endtask

    task automatic test_reset;
        exp_t e;
        rst = 1'b1;
        valid_in = 1'b1;
        x_in = $urandom; y_in = $urandom; z_in = $urandom;
        #2;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({vo[k], xo[k], yo[k], zo[k]} !== 97'b0) begin
                errors++;
                $display("FAIL reset_hold inst%0d: got v=%b x=%h y=%h z=%h required all 0", k, vo[k], xo[k], yo[k], zo[k]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, $urandom, $urandom, $urandom);
        checks++;
        if (vo[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: got valid_out=%b required 0", vo[0]);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({vo[k], xo[k], yo[k], zo[k]} !== {e.v, e.x[k], e.y[k], e.z[k]}) begin
                errors++;
                $display("FAIL reset_release inst%0d: got v=%b %h %h %h required v=%b %h %h %h",
                         k, vo[k], xo[k], yo[k], zo[k], e.v, e.x[k], e.y[k], e.z[k]);
            end
        end
    endtask

    task automatic test_pos_z;
        exp_t e;
        drive(1'b1, 32'h40000000, 32'h0, 32'h40000000);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({vo[0], xo[0], yo[0], zo[0]} !== {1'b1, 32'h40000000, 32'h20000000, 32'h20000000}) begin
            errors++;
            $display("FAIL pos_z: got v=%b %h %h %h required v=1 40000000 20000000 20000000", vo[0], xo[0], yo[0], zo[0]);
        end
    endtask

    task automatic test_neg_z;
        exp_t e;
        drive(1'b1, 32'h40000000, 32'h0, 32'hC0000000);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({vo[0], xo[0], yo[0], zo[0]} !== {1'b1, 32'h40000000, 32'hE0000000, 32'hE0000000}) begin
            errors++;
            $display("FAIL neg_z: got v=%b %h %h %h required v=1 40000000 e0000000 e0000000", vo[0], xo[0], yo[0], zo[0]);
        end
    endtask

    task automatic test_zero_z_stage0;
        exp_t e;
        drive(1'b1, 32'h40000000, 32'h0, 32'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({xo[1], yo[1], zo[1]} !== {32'h40000000, 32'h40000000, 32'hCDBC0957}) begin
            errors++;
            $display("FAIL zero_z_stage0: got %h %h %h required 40000000 40000000 cdbc0957", xo[1], yo[1], zo[1]);
        end
    endtask

    task automatic test_wrap_floor;
        exp_t e;
        drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({xo[2], yo[2], zo[2]} !== {32'h40000000, 32'hBFFFFFFE, 32'h0}) begin
            errors++;
            $display("FAIL wrap: got %h %h %h required 40000000 bffffffe 00000000", xo[2], yo[2], zo[2]);
        end
        drive(1'b1, 32'h0, 32'hFFFFFFFF, 32'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({xo[2], yo[2], zo[2]} !== {32'h00000001, 32'hFFFFFFFF, 32'h0}) begin
            errors++;
            $display("FAIL floor: got %h %h %h required 00000001 ffffffff 00000000", xo[2], yo[2], zo[2]);
        end
    endtask

    task automatic test_back_to_back;
        exp_t       e;
        logic [10:0] vpat = 11'b11_0_11111111;
        drive(vpat[0], $urandom, $urandom, $urandom);
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if ({vo[k], xo[k], yo[k], zo[k]} !== {e.v, e.x[k], e.y[k], e.z[k]}) begin
                    errors++;
                    $display("FAIL stream[%0d] inst%0d: got v=%b %h %h %h required v=%b %h %h %h",
                             n - 1, k, vo[k], xo[k], yo[k], zo[k], e.v, e.x[k], e.y[k], e.z[k]);
                end
            end
            if (n < 11) drive(vpat[n], $urandom, $urandom, $urandom);
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        drive(1'b1, 32'h40000000, 32'h12345678, 32'h40000000);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({vo[3], xo[3], yo[3], zo[3]} !== {e.v, e.x[3], e.y[3], e.z[3]}) begin
            errors++;
            $display("FAIL mid_pre inst3: got v=%b %h %h %h required v=%b %h %h %h",
                     vo[3], xo[3], yo[3], zo[3], e.v, e.x[3], e.y[3], e.z[3]);
        end
        drive(1'b1, $urandom, $urandom, $urandom);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({vo[k], xo[k], yo[k], zo[k]} !== 97'b0) begin
                errors++;
                $display("FAIL mid_reset inst%0d: got v=%b x=%h y=%h z=%h required all 0", k, vo[k], xo[k], yo[k], zo[k]);
            end
        end
        e = sb.pop_front();
        @(posedge clk); #1;
        checks++;
        if ({vo[0], xo[0], yo[0], zo[0]} !== 97'b0) begin
            errors++;
            $display("FAIL mid_reset_edge: got v=%b %h %h %h required all 0", vo[0], xo[0], yo[0], zo[0]);
        end
        rst = 1'b0;
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pos_z();
        test_neg_z();
        test_zero_z_stage0();
        test_wrap_floor();
        test_back_to_back();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
